block_stream_tx: RTL
====================

// Module: block_stream_tx
// PURPOSE
//  Transmit side of the block pixel stream that noise_estimation consumes.
//  Accepts a raster-order pixel stream, buffers one band of BLOCK_H rows, and
//  re-emits the pixels block by block (row-major inside each block).
//  Drives data/start_data/start_of_frame/blocks_per_frame to the estimator.
// PARAMETERS
//  DATA_WIDTH   8   pixel width
//  BLOCK_W      4   block width in pixels
//  BLOCK_H      2   block height; BLOCK_W*BLOCK_H = estimator TOTAL_SAMPLES
//  FRAME_WIDTH  16  pixels per row; must be a multiple of BLOCK_W
//  FRAME_HEIGHT 4   rows per frame; must be a multiple of BLOCK_H
//  BLOCK_GAP    1   idle cycles between consecutive output blocks (>=0)
// PORTS
//  clk              in   1    clock
//  rst_n            in   1    async active-low reset
//  pixel_in         in   DW   raster pixel
//  pixel_valid      in   1    pixel_in valid
//  sof_in           in   1    first pixel of frame; qualified by pixel_valid
//  pixel_ready      out  1    1 = pixel accepted when pixel_valid=1
//  data_out         out  DW   block-ordered pixel
//  data_valid       out  1    data_out valid
//  start_data       out  1    pulse with first pixel of each block
//  start_of_frame   out  1    pulse with first pixel of first block of frame
//  end_of_frame     out  1    pulse with last pixel of last block of frame
//  blocks_per_frame out  32   (FRAME_WIDTH/BLOCK_W)*(FRAME_HEIGHT/BLOCK_H)
//  sof_error        out  1    sticky: sof_in seen mid-frame
// BEHAVIOUR
//  Clock is clk; reset is asynchronous, active-low (rst_n).
//  Reset: all outputs 0 except blocks_per_frame (constant); state IDLE; counters 0.
//  FSM states: IDLE, FILL, DRAIN, GAP.
//   IDLE : pixel_ready=1; pixels without sof_in are dropped. valid&sof_in ->
//          pixel written at col0,row0, go FILL.
//   FILL : pixel_ready=1; accept on valid&ready, write to band buffer at
//          (row%BLOCK_H, col). Gaps in pixel_valid are allowed. Accept of
//          pixel (BLOCK_H-1, FRAME_WIDTH-1) of the band -> DRAIN next cycle.
//   DRAIN: pixel_ready=0. Emits BLOCK_W*BLOCK_H consecutive valid pixels per
//          block, block columns 0..NBX-1 in order. After each block: GAP if
//          BLOCK_GAP>0 else next block directly. After last block of band:
//          FILL if more bands, else IDLE.
//   GAP  : pixel_ready=0, data_valid=0 for BLOCK_GAP cycles, then DRAIN.
//  Latency: first block pixel appears on data_out 2 cycles after the accept
//   cycle of the band's last pixel (1 addr cycle + 1 registered read).
//  data_out/valid/start_data/start_of_frame/end_of_frame are registered,
//   mutually aligned; data_out holds last value when data_valid=0.
//  start_of_frame only on block 0 of band 0; end_of_frame on last pixel of
//   last block of last band, then IDLE on following cycle.
//  No backpressure from consumer: once a block starts it is never stalled.
//  sof_in with valid in FILL (not first pixel): sof_error<=1 (sticky until
//   reset), band restarts with that pixel as (0,0); pending frame discarded.
//   sof_in is never sampled in DRAIN/GAP (pixel_ready=0).
//  Counters: col (log2 FRAME_WIDTH), row-in-band, band, block-col, in-block
//   index; wrap to 0 at their limits; no arithmetic overflow possible.
//  Elaboration $error if divisibility rules fail or BLOCK_W*BLOCK_H not pow2.
// STRUCTURE
//  Package noise_pkg: blk_tx_state_t enum {IDLE,FILL,DRAIN,GAP}; localparam
//   helpers NBX, NBY, BAND_DEPTH=BLOCK_H*FRAME_WIDTH, clog2-based widths.
//  Sub-module band_buffer: simple dual-port RAM, DEPTH=BAND_DEPTH, width DW,
//   1 write port, 1 registered read port (1-cycle latency). Top holds FSM,
//   write/read address generation and output registers.
// TESTING  (defaults: FW=16, FH=4, BW=4, BH=2, GAP=1; pixel value = raster idx)
//  1 Frame 0..63 with sof_in on 0 -> blocks_per_frame=8; block0 = 0,1,2,3,16,
//    17,18,19; start_data+start_of_frame on pixel 0 only, 2 cyc after idx31 accepted.
//  2 Same frame -> block1 = 4..7,20..23 after exactly 1 idle cycle; block4 =
//    32..35,48..51; start_data on each block's first pixel, 8 pulses total.
//  3 End of frame -> end_of_frame with pixel 63 only; next cycle IDLE,
//    pixel_ready=1; pixels 100,101 without sof_in produce no output.
//  4 Random pixel_valid gaps (50%) in FILL -> output sequence identical to 1-2.
//  5 sof_in at raster idx 10 mid-FILL -> sof_error=1 sticky; band restarts;
//    block0 output = pixels from that restart (10..13 relative re-indexed).
//  6 rst_n low for 1 cycle mid-DRAIN -> all outputs 0 immediately (async);
//    subsequent full frame reproduces test 1 exactly; sof_error=0.

Source files
------------

// File: rtl/noise_pkg.sv
// Shared types and default geometry for the block pixel stream.
// Widths use cw() so single-entry dimensions still get a 1-bit counter.
package noise_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } blk_tx_state_t;

  localparam int DEF_FW     = 16;
  localparam int DEF_FH     = 4;
  localparam int DEF_BW     = 4;
  localparam int DEF_BH     = 2;
  localparam int NBX        = DEF_FW / DEF_BW;
  localparam int NBY        = DEF_FH / DEF_BH;
  localparam int BAND_DEPTH = DEF_BH * DEF_FW;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/block_stream_tx_band_buffer.sv
// One-band pixel store: one write port, one registered read port.
// The read register is the block stream data output, so it holds when idle.
module block_stream_tx_band_buffer
  import noise_pkg::*;
#(
  parameter int DEPTH = BAND_DEPTH,
  parameter int DW    = 8,
  parameter int AW    = cw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // storage write, no reset on the array itself
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // registered read, holds its value while not reading
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/block_stream_tx.sv
// Raster-to-block reorder: buffers one band of rows, then emits it
// block by block with a fixed idle gap between blocks.
module block_stream_tx
  import noise_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int BLOCK_W      = DEF_BW,
  parameter int BLOCK_H      = DEF_BH,
  parameter int FRAME_WIDTH  = DEF_FW,
  parameter int FRAME_HEIGHT = DEF_FH,
  parameter int BLOCK_GAP    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_valid,
  input  logic                  sof_in,
  output logic                  pixel_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  start_data,
  output logic                  start_of_frame,
  output logic                  end_of_frame,
  output logic [31:0]           blocks_per_frame,
  output logic                  sof_error
);

  localparam int C_NBX   = FRAME_WIDTH / BLOCK_W;
  localparam int C_NBY   = FRAME_HEIGHT / BLOCK_H;
  localparam int C_DEPTH = BLOCK_H * FRAME_WIDTH;
  localparam int C_BSZ   = BLOCK_W * BLOCK_H;
  localparam int AW      = cw(C_DEPTH);
  localparam int CW      = cw(FRAME_WIDTH);
  localparam int RW      = cw(BLOCK_H);
  localparam int BYW     = cw(C_NBY);
  localparam int BXW     = cw(C_NBX);
  localparam int XW      = cw(BLOCK_W);
  localparam int GW      = cw(BLOCK_GAP + 1);
  localparam int GLAST   = (BLOCK_GAP > 0) ? BLOCK_GAP - 1 : 0;

  localparam logic [CW-1:0]  COL_MAX  = CW'(FRAME_WIDTH - 1);
  localparam logic [RW-1:0]  ROW_MAX  = RW'(BLOCK_H - 1);
  localparam logic [XW-1:0]  BC_MAX   = XW'(BLOCK_W - 1);
  localparam logic [BXW-1:0] BX_MAX   = BXW'(C_NBX - 1);
  localparam logic [BYW-1:0] BAND_MAX = BYW'(C_NBY - 1);
  localparam logic [GW-1:0]  GAP_MAX  = GW'(GLAST);
  localparam logic [AW-1:0]  FW_A     = AW'(FRAME_WIDTH);
  localparam logic [AW-1:0]  BW_A     = AW'(BLOCK_W);

  if (FRAME_WIDTH % BLOCK_W != 0) begin : g_chk_w
    $error("FRAME_WIDTH must be a multiple of BLOCK_W");
  end
  if (FRAME_HEIGHT % BLOCK_H != 0) begin : g_chk_h
    $error("FRAME_HEIGHT must be a multiple of BLOCK_H");
  end
  if ((C_BSZ & (C_BSZ - 1)) != 0) begin : g_chk_p2
    $error("BLOCK_W*BLOCK_H must be a power of two");
  end

  blk_tx_state_t r_state, w_nstate;
  logic            r_ready;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [BYW-1:0]  r_band;
  logic [BXW-1:0]  r_bx;
  logic [XW-1:0]   r_bc;
  logic [RW-1:0]   r_br;
  logic [GW-1:0]   r_gap;
  logic            r_valid, r_sd, r_sof, r_eof, r_serr;

  logic            w_take, w_restart, w_band_done;
  logic            w_rd, w_blk_end, w_last_bx, w_last_band, w_first;
  logic [AW-1:0]   w_waddr, w_raddr;

  assign w_take      = pixel_valid & r_ready &
                       ((r_state == FILL) | sof_in);
  assign w_restart   = w_take & sof_in;
  assign w_band_done = w_take & ~sof_in &
                       (r_col == COL_MAX) & (r_row == ROW_MAX);
  assign w_rd        = (r_state == DRAIN);
  assign w_blk_end   = w_rd & (r_bc == BC_MAX) & (r_br == ROW_MAX);
  assign w_last_bx   = (r_bx == BX_MAX);
  assign w_last_band = (r_band == BAND_MAX);
  assign w_first     = w_rd & (r_bc == '0) & (r_br == '0);

  assign w_waddr = w_restart ? '0 :
                   AW'(r_row) * FW_A + AW'(r_col);
  assign w_raddr = AW'(r_br) * FW_A + AW'(r_bx) * BW_A + AW'(r_bc);

  // next-state decode
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE:  if (w_restart) w_nstate = FILL;
      FILL:  if (w_band_done) w_nstate = DRAIN;
      DRAIN: begin
        if (w_blk_end) begin
          if (w_last_bx)          w_nstate = w_last_band ? IDLE : FILL;
          else if (BLOCK_GAP > 0) w_nstate = GAP;
        end
      end
      GAP:   if (r_gap == GAP_MAX) w_nstate = DRAIN;
      default: w_nstate = IDLE;
    endcase
  end

  // state and registered input-ready (low throughout reset)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_ready <= (w_nstate == IDLE) | (w_nstate == FILL);
    end
  end

  // raster write position inside the band; sof restarts at (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_restart) begin
      r_col <= CW'(1);
      r_row <= '0;
    end else if (w_take) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // block read position, block column, band and gap counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bc   <= '0;
      r_br   <= '0;
      r_bx   <= '0;
      r_band <= '0;
      r_gap  <= '0;
    end else begin
      r_gap <= (r_state == GAP) ? r_gap + 1'b1 : '0;
      if (w_restart) r_band <= '0;
      if (w_rd) begin
        if (r_bc == BC_MAX) begin
          r_bc <= '0;
          r_br <= (r_br == ROW_MAX) ? '0 : r_br + 1'b1;
        end else begin
          r_bc <= r_bc + 1'b1;
        end
      end
      if (w_blk_end) begin
        r_bx <= w_last_bx ? '0 : r_bx + 1'b1;
        if (w_last_bx)
          r_band <= w_last_band ? '0 : r_band + 1'b1;
      end
    end
  end

  // output flags aligned with the one-cycle buffer read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sd    <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      r_serr  <= 1'b0;
    end else begin
      r_valid <= w_rd;
      r_sd    <= w_first;
      r_sof   <= w_first & (r_bx == '0) & (r_band == '0);
      r_eof   <= w_blk_end & w_last_bx & w_last_band;
      if (w_restart && r_state == FILL) r_serr <= 1'b1;
    end
  end

  block_stream_tx_band_buffer #(
    .DEPTH (C_DEPTH),
    .DW    (DATA_WIDTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_take),
    .i_waddr (w_waddr),
    .i_wdata (pixel_in),
    .i_re    (w_rd),
    .i_raddr (w_raddr),
    .o_rdata (data_out)
  );

  assign pixel_ready      = r_ready;
  assign data_valid       = r_valid;
  assign start_data       = r_sd;
  assign start_of_frame   = r_sof;
  assign end_of_frame     = r_eof;
  assign sof_error        = r_serr;
  assign blocks_per_frame = 32'(C_NBX * C_NBY);

endmodule
